// File: rtl/wb_mux3_arbiter.sv
// Round-robin arbiter that shares one 3:1 selection datapath between three requesters.
// The chosen word is registered and presented to the consumer with a valid/ready handshake.
module wb_mux3_arbiter #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       Req,
    input  logic [NBits-1:0] Data0,
    input  logic [NBits-1:0] Data1,
    input  logic [NBits-1:0] Data2,
    input  logic             Out_Ready,
    output logic [2:0]       Grant,
    output logic [1:0]       Selector,
    output logic [NBits-1:0] Out_Data,
    output logic             Out_Valid
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [NBits-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [2:0]       elig;
    logic [1:0]       last_eff;
    logic [1:0]       first_idx, second_idx, third_idx;
    logic [1:0]       winner;
    logic             have_winner;
    logic             capture;
    logic [NBits-1:0] data_in [3];

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign data_in[0] = Data0;
    assign data_in[1] = Data1;
    assign data_in[2] = Data2;

    // A requester whose grant is still showing cannot win again this edge.
    assign elig       = Req & ~grant_q;
    assign last_eff   = (last_q == 2'b11) ? 2'd2 : last_q;
    assign first_idx  = next_idx(last_eff);
    assign second_idx = next_idx(first_idx);
    assign third_idx  = next_idx(second_idx);
    assign capture    = (state_q == IDLE) || Out_Ready;

    always_comb begin
        have_winner = 1'b1;
        winner      = 2'd0;
        if (elig[first_idx]) begin
            winner = first_idx;
        end else if (elig[second_idx]) begin
            winner = second_idx;
        end else if (elig[third_idx]) begin
            winner = third_idx;
        end else begin
            have_winner = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = 3'b000;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (capture) begin
            if (have_winner) begin
                state_d = HOLD;
                last_d  = winner;
                grant_d = 3'b001 << winner;
                sel_d   = winner;
                data_d  = data_in[winner];
                valid_d = 1'b1;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'b10;
            grant_q <= 3'b000;
            sel_q   <= 2'b00;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Grant     = grant_q;
    assign Selector  = sel_q;
    assign Out_Data  = data_q;
    assign Out_Valid = valid_q;

endmodule

// File: tb/tb_wb_mux3_arbiter.sv
// Scoreboard bench for wb_mux3_arbiter: a behavioural model pushes expected outputs
// when inputs are applied, and each scenario pops and compares after the clock edge.
module tb_wb_mux3_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  Req;
    logic [31:0] Data0, Data1, Data2;
    logic        Out_Ready;
    logic [2:0]  Grant;
    logic [1:0]  Selector;
    logic [31:0] Out_Data;
    logic        Out_Valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  g;
        logic [1:0]  s;
        logic [31:0] d;
        logic        v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t got;

    // model state
    logic        m_hold;
    logic [1:0]  m_last;
    logic [2:0]  m_grant;
    logic [1:0]  m_sel;
    logic [31:0] m_data;
    logic        m_valid;

    wb_mux3_arbiter #(.NBits(32)) dut (
        .clk(clk), .reset(reset), .Req(Req),
        .Data0(Data0), .Data1(Data1), .Data2(Data2),
        .Out_Ready(Out_Ready), .Grant(Grant), .Selector(Selector),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    assign got = '{g: Grant, s: Selector, d: Out_Data, v: Out_Valid};

    task automatic model_reset();
        m_hold  = 1'b0;
        m_last  = 2'd2;
        m_grant = 3'b000;
        m_sel   = 2'd0;
        m_data  = 32'h0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    // Model one rising edge from the current inputs, queue the result, then step the clock.
    task automatic advance();
        logic [2:0] elig;
        int l, w;
        elig = Req & ~m_grant;
        l = (m_last == 2'b11) ? 2 : int'(m_last);
        w = -1;
        if (!m_hold || Out_Ready) begin
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (l + k) % 3;
                if (w < 0 && elig[i]) w = i;
            end
            if (w >= 0) begin
                m_hold  = 1'b1;
                m_last  = 2'(w);
                m_grant = 3'(1 << w);
                m_sel   = 2'(w);
                m_data  = (w == 0) ? Data0 : (w == 1) ? Data1 : Data2;
                m_valid = 1'b1;
            end else begin
                m_hold  = 1'b0;
                m_grant = 3'b000;
                m_valid = 1'b0;
            end
        end else begin
            m_grant = 3'b000;
        end
        sb.push_back('{g: m_grant, s: m_sel, d: m_data, v: m_valid});
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Req = 3'b000; Data0 = 0; Data1 = 0; Data2 = 0; Out_Ready = 1'b0;
        #12;
        checks++;
        if (got !== exp_t'(0)) begin
            failures++;
            $display("FAIL reset_values got=%h required=%h", got, exp_t'(0));
        end
        reset = 1'b1;
        model_reset();
        Out_Ready = 1'b1;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Out_Valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got=%h required=%h", got, e);
        end
    endtask

    task automatic test_single();
        apply_reset();
        Req = 3'b010; Data1 = 32'hA5A5_0001; Out_Ready = 1'b1;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL single_sb got=%h required=%h", got, e);
        end
        checks++;
        if (got !== {3'b010, 2'b01, 32'hA5A5_0001, 1'b1}) begin
            failures++;
            $display("FAIL single_capture got=%h required=%h", got, {3'b010, 2'b01, 32'hA5A5_0001, 1'b1});
        end
        Req = 3'b000;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Out_Valid !== 1'b0 || Grant !== 3'b000) begin
            failures++;
            $display("FAIL single_drain got=%h required=%h", got, e);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] gexp [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        logic [1:0] sexp [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        apply_reset();
        Req = 3'b111; Out_Ready = 1'b1;
        Data0 = 32'h1000_0000; Data1 = 32'h1111_1111; Data2 = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (got !== e || Grant !== gexp[i] || Selector !== sexp[i]) begin
                failures++;
                $display("FAIL fairness_%0d grant=%b sel=%b required grant=%b sel=%b (sb %h vs %h)",
                         i, Grant, Selector, gexp[i], sexp[i], got, e);
            end
        end
        Req = 3'b000;
        advance();
        void'(sb.pop_front());
    endtask

    task automatic test_backpressure();
        apply_reset();
        Req = 3'b100; Data2 = 32'h0000_00FF; Data0 = 32'hC0C0_0000; Out_Ready = 1'b1;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Out_Data !== 32'h0000_00FF || Grant !== 3'b100) begin
            failures++;
            $display("FAIL bp_capture got=%h required=%h", got, e);
        end
        Out_Ready = 1'b0; Req = 3'b011; Data2 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (got !== e || Out_Data !== 32'h0000_00FF || Out_Valid !== 1'b1 || Grant !== 3'b000) begin
                failures++;
                $display("FAIL bp_stall_%0d got=%h required=%h", i, got, e);
            end
        end
        Out_Ready = 1'b1;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Grant !== 3'b001 || Out_Data !== 32'hC0C0_0000) begin
            failures++;
            $display("FAIL bp_release got=%h required=%h", got, e);
        end
    endtask

    task automatic test_no_double_grant();
        apply_reset();
        Req = 3'b001; Data0 = 32'h0BAD_F00D; Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (got !== e || Grant !== ((i % 2 == 0) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL no_double_%0d grant=%b required=%b (sb %h vs %h)",
                         i, Grant, (i % 2 == 0) ? 3'b001 : 3'b000, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        Req = 3'b000; Out_Ready = 1'b1;
        advance(); void'(sb.pop_front());
        advance(); void'(sb.pop_front());
        Req = 3'b010; Data1 = 32'hDEAD_BEEF; Out_Ready = 1'b0;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Out_Valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup got=%h required=%h", got, e);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (got !== exp_t'(0)) begin
            failures++;
            $display("FAIL areset_immediate got=%h required=%h", got, exp_t'(0));
        end
        model_reset();
        Req = 3'b100; Data2 = 32'h7777_0002; Out_Ready = 1'b1;
        #1;
        reset = 1'b1;
        advance();
        e = sb.pop_front();
        checks++;
        if (got !== e || Grant !== 3'b100) begin
            failures++;
            $display("FAIL areset_first_grant got=%h required=%h", got, e);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 10000; i++) begin
            Req = 3'($urandom_range(0, 7));
            Out_Ready = ($urandom_range(0, 3) != 0);
            Data0 = $urandom; Data1 = $urandom; Data2 = $urandom;
            advance();
            e = sb.pop_front();
            checks++;
            if (got !== e || Selector === 2'b11 || $countones(Grant) > 1) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d got=%h required=%h", i, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_no_double_grant();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
